// File: rtl/cpu_control.sv
// ----------------------------------------------------------------------------
// cpu_control
//
// Control unit for a small 8-bit accumulator CPU. It fetches instructions
// from a combinational-read instruction memory, sequences one- and two-byte
// instructions through FETCH / OPERAND / EXEC, drives an external ALU and
// holds the architectural state: PC, IR, OPND, ACC, R0-R3 and the Z/C flags.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   run         allows the FSM to leave FETCH; while low the FSM idles there
//   instr_addr  instruction memory address (always the PC)
//   instr_data  instruction memory byte at instr_addr, valid the same cycle
//   alu_a       ALU operand A (ACC)
//   alu_b       ALU operand B (R[IR[1:0]])
//   alu_op      ALU operation (IR[5:4]: ADD, SUB, AND, OR)
//   alu_result  ALU result byte
//   alu_zero    ALU result-is-zero
//   alu_carry   bit 8 of the 9-bit ALU result
//   acc_out     accumulator
//   flag_z      zero flag
//   flag_c      carry flag
//   halted      high while the CPU sits in HALT
// ----------------------------------------------------------------------------
module cpu_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic [7:0] instr_addr,
    input  logic [7:0] instr_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_carry,
    output logic [7:0] acc_out,
    output logic       flag_z,
    output logic       flag_c,
    output logic       halted
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_LDI = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_OPERAND = 2'd1,
        S_EXEC    = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] pc_reg,   pc_next;
    logic [7:0] ir_reg,   ir_next;
    logic [7:0] opnd_reg, opnd_next;
    logic [7:0] acc_reg,  acc_next;
    logic       z_reg,    z_next;
    logic       c_reg,    c_next;
    logic [7:0] r_reg [4];
    logic [3:0] r_we;

    logic [3:0] opcode;
    logic [1:0] rsel;
    logic       unused_ir_bits;

    assign opcode = ir_reg[7:4];
    assign rsel   = ir_reg[1:0];
    // IR[3:2] carry no meaning for any opcode.
    assign unused_ir_bits = ^ir_reg[3:2];

    // Opcodes that carry a second (operand) byte.
    function automatic logic is_two_byte(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
    endfunction

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        opnd_next  = opnd_reg;
        acc_next   = acc_reg;
        z_next     = z_reg;
        c_next     = c_reg;

        case (state_reg)
            S_FETCH: begin
                if (run) begin
                    ir_next    = instr_data;
                    pc_next    = pc_reg + 8'd1;
                    state_next = is_two_byte(instr_data[7:4]) ? S_OPERAND : S_EXEC;
                end
            end

            S_OPERAND: begin
                opnd_next  = instr_data;
                pc_next    = pc_reg + 8'd1;
                state_next = S_EXEC;
            end

            S_EXEC: begin
                state_next = S_FETCH;
                case (opcode)
                    OP_LDA: acc_next = r_reg[rsel];
                    OP_LDI: acc_next = opnd_reg;
                    4'h4, 4'h5, 4'h6, 4'h7: begin
                        acc_next = alu_result;
                        z_next   = alu_zero;
                        c_next   = alu_carry;
                    end
                    OP_JMP: pc_next = opnd_reg;
                    OP_JZ:  if (z_reg) pc_next = opnd_reg;
                    OP_JC:  if (c_reg) pc_next = opnd_reg;
                    OP_HLT: state_next = S_HALT;
                    // OP_NOP, OP_MOV (handled by r_we) and undefined opcodes
                    // change nothing here.
                    default: ;
                endcase
            end

            // Frozen until reset.
            S_HALT: ;

            default: state_next = S_FETCH;
        endcase
    end

    // Register-file write strobes: only MOV in EXEC writes, and only R[r].
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rf_we
            assign r_we[gi] = (state_reg == S_EXEC) && (opcode == OP_MOV) &&
                              (rsel == 2'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            pc_reg    <= 8'h00;
            ir_reg    <= 8'h00;
            opnd_reg  <= 8'h00;
            acc_reg   <= 8'h00;
            z_reg     <= 1'b0;
            c_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            opnd_reg  <= opnd_next;
            acc_reg   <= acc_next;
            z_reg     <= z_next;
            c_reg     <= c_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_reg[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_we[i]) begin
                    r_reg[i] <= acc_reg;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign instr_addr = pc_reg;
    assign alu_a      = acc_reg;
    assign alu_b      = r_reg[rsel];
    assign alu_op     = ir_reg[5:4];
    assign acc_out    = acc_reg;
    assign flag_z     = z_reg;
    assign flag_c     = c_reg;
    assign halted     = (state_reg == S_HALT);

endmodule

// File: tb/tb_cpu_control.sv
// ----------------------------------------------------------------------------
// tb_cpu_control
//
// Self-checking bench for cpu_control. Provides a 256-byte instruction
// memory and an ALU around the DUT, keeps an instruction-level reference
// model (each instruction's architectural effect computed at once and made
// visible when its latency has elapsed) that is compared against the DUT on
// every falling edge, and adds hand-computed checkpoints for the reference
// programs.
// ----------------------------------------------------------------------------
module tb_cpu_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [7:0] instr_addr;
    logic [7:0] instr_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;
    logic [7:0] acc_out;
    logic       flag_z;
    logic       flag_c;
    logic       halted;

    int n_cmp;
    int n_err;

    logic [7:0] mem [256];
    logic [8:0] alu_full;

    always #5 clk = ~clk;

    cpu_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .acc_out    (acc_out),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .halted     (halted)
    );

    // Environment: combinational memory and ALU.
    assign instr_data = mem[instr_addr];

    always_comb begin
        case (alu_op)
            2'd0:    alu_full = {1'b0, alu_a} + {1'b0, alu_b};
            2'd1:    alu_full = {1'b0, alu_a} - {1'b0, alu_b};
            2'd2:    alu_full = {1'b0, alu_a & alu_b};
            default: alu_full = {1'b0, alu_a | alu_b};
        endcase
    end
    assign alu_result = alu_full[7:0];
    assign alu_carry  = alu_full[8];
    assign alu_zero   = (alu_full[7:0] == 8'h00);

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: architectural state plus the pending effect of the
    // instruction in flight and how many edges remain until it lands.
    // ------------------------------------------------------------------
    logic [7:0] m_pc, m_vis_pc, m_acc, m_ir;
    logic [7:0] m_regs [4];
    logic       m_z, m_c, m_halt;
    int         m_left;
    logic [7:0] p_pc, p_acc, p_val;
    logic [1:0] p_idx;
    logic       p_z, p_c, p_halt, p_we;

    task automatic model_reset();
        m_pc = 8'h00; m_vis_pc = 8'h00; m_acc = 8'h00; m_ir = 8'h00;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0; m_left = 0;
    endtask

    task automatic model_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                             output logic [7:0] res, output logic z, output logic c);
        int full;
        case (op)
            2'd0:    full = int'(a) + int'(b);
            2'd1:    full = int'(a) - int'(b);
            2'd2:    full = int'(a & b);
            default: full = int'(a | b);
        endcase
        res = full[7:0];
        c   = full[8];
        z   = (res == 8'h00);
    endtask

    // One clock edge's worth of progress, given the run level at that edge.
    task automatic model_step();
        logic [7:0] op, o;
        int len;
        if (m_halt) return;
        if (m_left == 0) begin
            if (!run) return;
            op  = mem[m_pc];
            o   = mem[8'(m_pc + 8'd1)];
            len = (op[7:4] == 4'h3 || op[7:4] == 4'h8 || op[7:4] == 4'h9 || op[7:4] == 4'hA) ? 2 : 1;
            p_pc = m_pc + 8'(len);
            p_acc = m_acc; p_z = m_z; p_c = m_c; p_halt = 1'b0;
            p_we = 1'b0; p_idx = op[1:0]; p_val = m_acc;
            case (op[7:4])
                4'h1: p_we = 1'b1;
                4'h2: p_acc = m_regs[op[1:0]];
                4'h3: p_acc = o;
                4'h4, 4'h5, 4'h6, 4'h7: model_alu(op[5:4], m_acc, m_regs[op[1:0]], p_acc, p_z, p_c);
                4'h8: p_pc = o;
                4'h9: if (m_z) p_pc = o;
                4'hA: if (m_c) p_pc = o;
                4'hF: p_halt = 1'b1;
                default: ;
            endcase
            m_ir = op;
            m_vis_pc = m_pc + 8'd1;
            m_left = len;
        end else begin
            m_left = m_left - 1;
            if (m_left > 0) begin
                m_vis_pc = m_pc + 8'd2;
            end else begin
                $display("instr %02h at %02h -> pc=%02h acc=%02h z=%0d c=%0d halt=%0d",
                         m_ir, m_pc, p_pc, p_acc, p_z, p_c, p_halt);
                m_pc = p_pc; m_vis_pc = p_pc; m_acc = p_acc;
                m_z = p_z; m_c = p_c; m_halt = p_halt;
                if (p_we) m_regs[p_idx] = p_val;
            end
        end
    endtask

    // Compare process: DUT outputs are sampled on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            else        model_step();
            check("m_pc",     instr_addr,     m_vis_pc);
            check("m_acc",    acc_out,        m_acc);
            check("m_alu_a",  alu_a,          m_acc);
            check("m_alu_b",  alu_b,          m_regs[m_ir[1:0]]);
            check("m_alu_op", 8'(alu_op),     8'(m_ir[5:4]));
            check("m_z",      8'(flag_z),     8'(m_z));
            check("m_c",      8'(flag_c),     8'(m_c));
            check("m_halted", 8'(halted),     8'(m_halt));
        end
    end

    // Advance n rising edges, then sit on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic load_prog1();
        logic [7:0] p [16];
        p = '{8'h30, 8'h05, 8'h11, 8'h30, 8'h03, 8'h41, 8'h30, 8'h03,
              8'h51, 8'h21, 8'h51, 8'h90, 8'h20, 8'h00, 8'h00, 8'h00};
        clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = p[i];
        mem[8'h20] = 8'hF0;
    endtask

    task automatic load_prog2();
        logic [7:0] p [9];
        p = '{8'h7A, 8'h30, 8'h7F, 8'h11, 8'h30, 8'h90, 8'h41, 8'h80, 8'h10};
        clear_mem();
        for (int i = 0; i < 9; i++) mem[i] = p[i];
        mem[8'h10] = 8'h90; mem[8'h11] = 8'h40;
        mem[8'h12] = 8'hA0; mem[8'h13] = 8'hFF;
        mem[8'hFF] = 8'h30;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        run   = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        load_prog1();
        @(negedge clk);
        check("rst_pc",     instr_addr,  8'h00);
        check("rst_acc",    acc_out,     8'h00);
        check("rst_z",      8'(flag_z),  8'h00);
        check("rst_c",      8'(flag_c),  8'h00);
        check("rst_halted", 8'(halted),  8'h00);
        #2 rst_n = 1'b1; run = 1'b1;

        // LDI 05, MOV R1, LDI 03, ADD R1
        step(10);
        check("add_acc", acc_out,    8'h08);
        check("add_pc",  instr_addr, 8'h06);
        check("add_z",   8'(flag_z), 8'h00);
        check("add_c",   8'(flag_c), 8'h00);
        check("add_r1",  alu_b,      8'h05);
        // LDI 03, SUB R1
        step(5);
        check("sub1_acc", acc_out,    8'hFE);
        check("sub1_c",   8'(flag_c), 8'h01);
        check("sub1_z",   8'(flag_z), 8'h00);
        // LDA R1, SUB R1
        step(4);
        check("sub2_acc", acc_out,    8'h00);
        check("sub2_z",   8'(flag_z), 8'h01);
        check("sub2_c",   8'(flag_c), 8'h00);
        // JZ 20 taken
        step(3);
        check("jz_taken_pc", instr_addr, 8'h20);
        // HLT
        step(2);
        check("hlt_halted", 8'(halted), 8'h01);
        check("hlt_pc",     instr_addr, 8'h21);
        step(20);
        check("hlt_hold_pc",     instr_addr, 8'h21);
        check("hlt_hold_acc",    acc_out,    8'h00);
        check("hlt_hold_halted", 8'(halted), 8'h01);

        // Reset out of HALT, second program.
        #2 rst_n = 1'b0;
        load_prog2();
        @(negedge clk);
        check("rst2_halted", 8'(halted), 8'h00);
        check("rst2_pc",     instr_addr, 8'h00);
        #2 rst_n = 1'b1;
        step(2);   // OR R2 at 0x00
        check("or_z",   8'(flag_z), 8'h01);
        check("or_pc",  instr_addr, 8'h01);
        step(10);  // LDI 7F, MOV R1, LDI 90, ADD R1
        check("add2_acc", acc_out,    8'h0F);
        check("add2_z",   8'(flag_z), 8'h00);
        check("add2_c",   8'(flag_c), 8'h01);
        step(3);   // JMP 10
        check("jmp_pc", instr_addr, 8'h10);
        step(3);   // JZ 40 not taken
        check("jz_nt_pc", instr_addr, 8'h12);
        check("jz_nt_z",  8'(flag_z), 8'h00);
        check("jz_nt_c",  8'(flag_c), 8'h01);
        step(3);   // JC FF taken
        check("jc_pc", instr_addr, 8'hFF);
        step(3);   // LDI at FF, operand from 00
        check("wrap_acc", acc_out,    8'h7A);
        check("wrap_pc",  instr_addr, 8'h01);

        // Idle in FETCH.
        #2 run = 1'b0;
        step(5);
        check("idle_pc", instr_addr, 8'h01);
        check("idle_ir", 8'(alu_op), 8'h03);
        #2 run = 1'b1;
        step(9);   // through the fetch of ADD at 06
        check("pre_rst_pc",  instr_addr, 8'h07);
        check("pre_rst_acc", acc_out,    8'h90);

        // Reset during EXEC of ADD.
        #2 rst_n = 1'b0;
        step(1);
        check("midrst_pc",  instr_addr, 8'h00);
        check("midrst_acc", acc_out,    8'h00);
        check("midrst_c",   8'(flag_c), 8'h00);
        step(2);
        check("midrst_hold_acc", acc_out, 8'h00);
        #2 run = 1'b0; rst_n = 1'b1;
        step(3);
        check("post_rst_idle_pc", instr_addr, 8'h00);
        #2 run = 1'b1;
        step(1);
        check("first_fetch_pc", instr_addr, 8'h01);
        check("first_fetch_op", 8'(alu_op), 8'h03);
        step(1);
        check("first_exec_z", 8'(flag_z), 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
